mdu_issue_ctrl: RTL and testbench
=================================

// Module: mdu_issue_ctrl
// PURPOSE
//  Sequences the multiply/divide unit (MDU) for the E stage. Buffers MDU write-type ops
//  (MTHI/MTLO/MULT/MULTU/DIV/DIVU) in an in-order FIFO and issues each when the MDU is idle.
//  Serves MFHI/MFLO only after all earlier ops have retired, and returns the result with a
//  valid pulse. Generates the pipeline stall and forwards interrupt aborts to the MDU.
// PARAMETERS
//  DEPTH  2   FIFO entries for write-type ops (power of 2, >=2)
//  DW     32  operand/result width
// PORTS
//  clk        in   1     clock, all state on posedge
//  clr        in   1     synchronous active-high reset
//  req_valid  in   1     E stage presents an MDU op
//  req_op     in   4     op code = MDU CTL code: 0 MFLO,1 MFHI,2 MTHI,3 MTLO,4 MULT,5 MULTU,6 DIV,7 DIVU
//  req_rs     in   DW    rs operand
//  req_rt     in   DW    rt operand
//  req_ready  out  1     op accepted on this edge when req_valid&req_ready
//  stall      out  1     req_valid & ~req_ready (pipeline freeze)
//  rd_valid   out  1     one-cycle pulse: rd_data holds MFHI/MFLO result
//  rd_data    out  DW    registered read result
//  irq        in   1     interrupt taken this cycle: abort/flush
//  mdu_ctl    out  4     MDU CTL; 4'hF = no-op
//  mdu_rsd    out  DW    MDU RSD
//  mdu_rtd    out  DW    MDU RTD
//  mdu_busy   in   1     MDU busy
//  mdu_out    in   DW    MDU HI/LO read data
//  mdu_irq    out  1     MDU IRQ (= irq)
// BEHAVIOUR
//  Reset (clr): FIFO empty, rd_pend=0, state IDLE, rd_valid=0, rd_data=0; mdu_ctl=4'hF.
//  Ops 8-15 on req: accepted and discarded (no enqueue, no read).
//  req_ready = ~clr & ~irq & ~rd_pend & ~full. Ops 2-7 push FIFO {op,rs,rt}; ops 0/1 set
//   rd_pend and store rd_op. No bypass: accept->earliest mdu_ctl drive is next cycle.
//  Full FIFO with pop same cycle: still not ready (ready uses registered full only).
//  FSM (registered), outputs combinational from state/FIFO head:
//   IDLE: if ~fifo_empty & ~mdu_busy: mdu_ctl/rsd/rtd = head, pop on edge;
//         op 4-7 -> WAIT, op 2/3 -> IDLE.
//         elif fifo_empty & rd_pend & ~mdu_busy: mdu_ctl=rd_op -> READ.
//         else mdu_ctl=4'hF.
//   WAIT: mdu_ctl=4'hF; -> IDLE when mdu_busy==0 (MDU asserts busy the cycle after issue).
//   READ: mdu_ctl=rd_op (held); on edge capture rd_data<=mdu_out, rd_valid<=1, rd_pend<=0 -> IDLE.
//  rd_valid is high exactly one cycle; read latency from accept (idle, empty) = 3 edges.
//  Reads are ordered after every earlier accepted op; no op accepted while rd_pend.
//  FIFO ptrs wrap modulo DEPTH; count width clog2(DEPTH)+1.
//  irq (priority over all but clr): mdu_irq=1, mdu_ctl=4'hF that cycle, FIFO flushed,
//   rd_pend=0, state->IDLE, rd_valid=0 next cycle. An in-flight MULT/DIV is aborted by the
//   MDU; HI/LO keep prior values. Already-issued MTHI/MTLO are not undone.
//  clr mid-operation: same as reset; MDU cleared by its own clr.
// TESTING
//  MULT rs=3,rt=-4 then MFLO: ctl 4 issued once, stall during busy; rd_valid with rd_data=-12.
//  DIVU 7/2 then MFHI: ctl 7 then WAIT ~10 cycles; rd_data=1; then MFLO -> 3.
//  MTHI 5, MTLO 6, MULT back-to-back (DEPTH=2): 3rd req stalled until pop; order 2,3,4 on ctl.
//  MULT issued, irq 2 cycles later with MFLO pending: mdu_irq=1, FIFO empty, no rd_valid.
//  MFHI with empty FIFO, MDU idle: accept at edge 0, mdu_ctl=1 cycle 1, rd_valid cycle 3.
//  clr asserted in WAIT with 2 queued ops: next cycle mdu_ctl=4'hF, req_ready=1, rd_valid=0.

Source files
------------

// File: rtl/mdu_issue_ctrl.sv
// Issue controller for the multiply/divide unit: queues write-type ops in order,
// serialises MFHI/MFLO behind them, and forwards interrupt aborts to the MDU.
module mdu_issue_ctrl #(
    parameter int DEPTH = 2,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          req_valid,
    input  logic [3:0]    req_op,
    input  logic [DW-1:0] req_rs,
    input  logic [DW-1:0] req_rt,
    output logic          req_ready,
    output logic          stall,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    input  logic          irq,
    output logic [3:0]    mdu_ctl,
    output logic [DW-1:0] mdu_rsd,
    output logic [DW-1:0] mdu_rtd,
    input  logic          mdu_busy,
    input  logic [DW-1:0] mdu_out,
    output logic          mdu_irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [3:0] CTL_NOP = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        READ
    } state_t;

    state_t state_q, state_d;

    logic [3:0]    op_mem [DEPTH];
    logic [DW-1:0] rs_mem [DEPTH];
    logic [DW-1:0] rt_mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;

    logic       rd_pend;
    logic [3:0] rd_op;

    logic full, empty, accept, is_wr_op, is_rd_op, push, pop, capture;
    logic [3:0] head_op;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign head_op  = op_mem[rd_ptr];

    // Readiness looks only at registered state, so a full FIFO stays not-ready
    // even in the cycle its head is popped.
    assign req_ready = ~clr & ~irq & ~rd_pend & ~full;
    assign stall     = req_valid & ~req_ready;
    assign accept    = req_valid & req_ready;
    assign is_wr_op  = (req_op >= 4'd2) && (req_op <= 4'd7);
    assign is_rd_op  = (req_op[3:1] == 3'b000);
    assign push      = accept & is_wr_op;
    assign mdu_irq   = irq;

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        mdu_ctl = CTL_NOP;
        mdu_rsd = rs_mem[rd_ptr];
        mdu_rtd = rt_mem[rd_ptr];
        pop     = 1'b0;
        capture = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty && !mdu_busy) begin
                    mdu_ctl = head_op;
                    pop     = 1'b1;
                    if (head_op[2]) state_d = WAIT;
                end else if (empty && rd_pend && !mdu_busy) begin
                    mdu_ctl = rd_op;
                    state_d = READ;
                end
            end
            WAIT: begin
                if (!mdu_busy) state_d = IDLE;
            end
            READ: begin
                mdu_ctl = rd_op;
                capture = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (clr || irq) begin
            mdu_ctl = CTL_NOP;
            pop     = 1'b0;
            capture = 1'b0;
            state_d = IDLE;
        end
    end

    // NOTE: FIFO storage has no reset; validity is tracked by count and pointers alone.
    always_ff @(posedge clk) begin
        if (push) begin
            op_mem[wr_ptr] <= req_op;
            rs_mem[wr_ptr] <= req_rs;
            rt_mem[wr_ptr] <= req_rt;
        end
    end

    // NOTE: all state registers use non-blocking assignments so every reader sees pre-edge values.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_pend  <= 1'b0;
            rd_op    <= 4'd0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else if (irq) begin
            state_q  <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_pend  <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_valid <= capture;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (capture) begin
                rd_data <= mdu_out;
                rd_pend <= 1'b0;
            end
            if (accept && is_rd_op) begin
                rd_pend <= 1'b1;
                rd_op   <= req_op;
            end
        end
    end

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Directed bench for mdu_issue_ctrl with a small behavioural MDU (multi-cycle
// mult/div, HI/LO registers, abort on irq).
module tb_mdu_issue_ctrl;

    logic        clk = 1'b0;
    logic        clr;
    logic        req_valid;
    logic [3:0]  req_op;
    logic [31:0] req_rs, req_rt;
    logic        req_ready, stall, rd_valid;
    logic [31:0] rd_data;
    logic        irq;
    logic [3:0]  mdu_ctl;
    logic [31:0] mdu_rsd, mdu_rtd, mdu_out;
    logic        mdu_busy, mdu_irq;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    mdu_issue_ctrl #(.DEPTH(2), .DW(32)) dut (
        .clk(clk), .clr(clr), .req_valid(req_valid), .req_op(req_op),
        .req_rs(req_rs), .req_rt(req_rt), .req_ready(req_ready), .stall(stall),
        .rd_valid(rd_valid), .rd_data(rd_data), .irq(irq), .mdu_ctl(mdu_ctl),
        .mdu_rsd(mdu_rsd), .mdu_rtd(mdu_rtd), .mdu_busy(mdu_busy),
        .mdu_out(mdu_out), .mdu_irq(mdu_irq)
    );

    // Behavioural MDU: mult busy 3 cycles, div busy 10 cycles after the issue edge.
    logic        m_busy, force_busy;
    logic [3:0]  m_cnt;
    logic [31:0] m_hi, m_lo, r_hi, r_lo;
    logic [63:0] prod;
    logic [3:0]  issued [$];

    assign mdu_busy = m_busy | force_busy;
    assign mdu_out  = (mdu_ctl == 4'd1) ? m_hi : m_lo;

    always @(posedge clk) begin
        if (!clr && mdu_ctl >= 4'd2 && mdu_ctl <= 4'd7) issued.push_back(mdu_ctl);
        if (clr) begin
            m_busy <= 1'b0; m_cnt <= 4'd0; m_hi <= 32'd0; m_lo <= 32'd0;
        end else if (mdu_irq) begin
            m_busy <= 1'b0;
        end else if (m_busy) begin
            if (m_cnt == 4'd0) begin
                m_busy <= 1'b0; m_hi <= r_hi; m_lo <= r_lo;
            end else begin
                m_cnt <= m_cnt - 4'd1;
            end
        end else begin
            case (mdu_ctl)
                4'd2: m_hi <= mdu_rsd;
                4'd3: m_lo <= mdu_rsd;
                4'd4: begin
                    prod = {{32{mdu_rsd[31]}}, mdu_rsd} * {{32{mdu_rtd[31]}}, mdu_rtd};
                    r_hi <= prod[63:32]; r_lo <= prod[31:0]; m_busy <= 1'b1; m_cnt <= 4'd2;
                end
                4'd5: begin
                    prod = {32'd0, mdu_rsd} * {32'd0, mdu_rtd};
                    r_hi <= prod[63:32]; r_lo <= prod[31:0]; m_busy <= 1'b1; m_cnt <= 4'd2;
                end
                4'd6: begin
                    r_lo <= $signed(mdu_rsd) / $signed(mdu_rtd);
                    r_hi <= $signed(mdu_rsd) % $signed(mdu_rtd);
                    m_busy <= 1'b1; m_cnt <= 4'd9;
                end
                4'd7: begin
                    r_lo <= mdu_rsd / mdu_rtd; r_hi <= mdu_rsd % mdu_rtd;
                    m_busy <= 1'b1; m_cnt <= 4'd9;
                end
                default: ;
            endcase
        end
    end

    // Advance to 1 time unit after the next falling edge.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_accept(input string name);
        int n = 0;
        #1;
        while (!req_ready && n < 50) begin
            step();
            n++;
        end
        if (n == 50) begin
            total++;
            $display("FAIL %s: req_ready never rose within 50 cycles", name);
        end
        step();
        req_valid = 1'b0;
    endtask

    // Presents one op and returns in the cycle after the accepting edge.
    task automatic send(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        input string name);
        req_valid = 1'b1; req_op = op; req_rs = rs; req_rt = rt;
        wait_accept(name);
    endtask

    task automatic wait_rd(input logic [31:0] exp, input string name, output int n);
        n = 0;
        while (!rd_valid && n < 60) begin
            step();
            n++;
        end
        total++;
        if (!rd_valid) $display("FAIL %s: rd_valid never pulsed, expected data %h", name, exp);
        else if (rd_data !== exp) $display("FAIL %s: rd_data got %h, expected %h", name, rd_data, exp);
        else passed++;
        step();
        total++;
        if (rd_valid !== 1'b0) $display("FAIL %s_pulse: rd_valid got %b, expected 0", name, rd_valid);
        else passed++;
    endtask

    task automatic test_reset();
        clr = 1'b1; irq = 1'b0; req_valid = 1'b0; req_op = 4'd0; req_rs = 0; req_rt = 0;
        force_busy = 1'b0;
        step(); step();
        total++;
        if (mdu_ctl !== 4'hF) $display("FAIL reset_ctl: got %h, expected f", mdu_ctl); else passed++;
        total++;
        if (rd_valid !== 1'b0 || rd_data !== 32'd0)
            $display("FAIL reset_rd: got %b/%h, expected 0/0", rd_valid, rd_data);
        else passed++;
        total++;
        if (req_ready !== 1'b0) $display("FAIL reset_ready_in_clr: got %b, expected 0", req_ready); else passed++;
        clr = 1'b0;
        #1;
        total++;
        if (req_ready !== 1'b1 || stall !== 1'b0 || mdu_irq !== 1'b0)
            $display("FAIL reset_ready: got ready=%b stall=%b irq=%b, expected 1 0 0", req_ready, stall, mdu_irq);
        else passed++;
    endtask

    task automatic test_mult_mflo();
        int n;
        issued.delete();
        send(4'd4, 32'd3, 32'hFFFF_FFFC, "mult_send");
        total++;
        if (mdu_ctl !== 4'd4) $display("FAIL mult_ctl: got %h, expected 4", mdu_ctl); else passed++;
        send(4'd0, 32'd0, 32'd0, "mflo_send");
        req_valid = 1'b1; req_op = 4'd15;
        #1;
        total++;
        if (stall !== 1'b1 || mdu_busy !== 1'b1)
            $display("FAIL mult_stall: got stall=%b busy=%b, expected 1 1", stall, mdu_busy);
        else passed++;
        req_valid = 1'b0;
        wait_rd(32'hFFFF_FFF4, "mult_mflo_data", n);
        total++;
        if (issued.size() != 1 || issued[0] !== 4'd4)
            $display("FAIL mult_issue_once: got %0d issues, expected exactly one ctl 4", issued.size());
        else passed++;
    endtask

    task automatic test_divu();
        int n;
        issued.delete();
        send(4'd7, 32'd7, 32'd2, "divu_send");
        total++;
        if (mdu_ctl !== 4'd7) $display("FAIL divu_ctl: got %h, expected 7", mdu_ctl); else passed++;
        send(4'd1, 32'd0, 32'd0, "mfhi_send");
        wait_rd(32'd1, "divu_mfhi_data", n);
        total++;
        if (n < 10) $display("FAIL divu_wait: got %0d cycles to rd_valid, expected at least 10", n); else passed++;
        send(4'd0, 32'd0, 32'd0, "mflo_send2");
        wait_rd(32'd3, "divu_mflo_data", n);
    endtask

    task automatic test_back_to_back();
        int n;
        issued.delete();
        force_busy = 1'b1;
        send(4'd2, 32'd5, 32'd0, "mthi_send");
        send(4'd3, 32'd6, 32'd0, "mtlo_send");
        req_valid = 1'b1; req_op = 4'd4; req_rs = 32'd2; req_rt = 32'd3;
        #1;
        total++;
        if (stall !== 1'b1) $display("FAIL b2b_full_stall: got %b, expected 1", stall); else passed++;
        step();
        total++;
        if (stall !== 1'b1) $display("FAIL b2b_full_stall2: got %b, expected 1", stall); else passed++;
        force_busy = 1'b0;
        #1;
        total++;
        if (req_ready !== 1'b0 || mdu_ctl !== 4'd2)
            $display("FAIL b2b_pop_cycle: got ready=%b ctl=%h, expected 0 2", req_ready, mdu_ctl);
        else passed++;
        wait_accept("b2b_mult");
        send(4'd0, 32'd0, 32'd0, "b2b_mflo");
        wait_rd(32'd6, "b2b_mflo_data", n);
        total++;
        if (issued.size() != 3 || issued[0] !== 4'd2 || issued[1] !== 4'd3 || issued[2] !== 4'd4)
            $display("FAIL b2b_order: got %0d issues, expected order 2,3,4", issued.size());
        else passed++;
    endtask

    task automatic test_irq();
        int n;
        int seen = 0;
        issued.delete();
        send(4'd4, 32'd100, 32'd100, "irq_mult");
        send(4'd0, 32'd0, 32'd0, "irq_mflo");
        step();
        irq = 1'b1;
        #1;
        total++;
        if (mdu_irq !== 1'b1 || mdu_ctl !== 4'hF || req_ready !== 1'b0)
            $display("FAIL irq_cycle: got irq=%b ctl=%h ready=%b, expected 1 f 0", mdu_irq, mdu_ctl, req_ready);
        else passed++;
        step();
        irq = 1'b0;
        #1;
        total++;
        if (req_ready !== 1'b1 || rd_valid !== 1'b0 || mdu_ctl !== 4'hF)
            $display("FAIL irq_after: got ready=%b rd_valid=%b ctl=%h, expected 1 0 f", req_ready, rd_valid, mdu_ctl);
        else passed++;
        for (int i = 0; i < 15; i++) begin
            if (rd_valid) seen++;
            step();
        end
        total++;
        if (seen != 0 || issued.size() != 1)
            $display("FAIL irq_flush: got %0d rd_valid, %0d issues, expected 0 and 1", seen, issued.size());
        else passed++;
        send(4'd0, 32'd0, 32'd0, "irq_mflo_after");
        wait_rd(32'd6, "irq_lo_kept", n);
    endtask

    task automatic test_mfhi_latency();
        send(4'd2, 32'h1234, 32'd0, "lat_mthi");
        step(); step();
        send(4'd1, 32'd0, 32'd0, "lat_mfhi");
        total++;
        if (mdu_ctl !== 4'd1 || rd_valid !== 1'b0)
            $display("FAIL lat_c1: got ctl=%h rd_valid=%b, expected 1 0", mdu_ctl, rd_valid);
        else passed++;
        step();
        total++;
        if (mdu_ctl !== 4'd1 || rd_valid !== 1'b0)
            $display("FAIL lat_c2: got ctl=%h rd_valid=%b, expected 1 0", mdu_ctl, rd_valid);
        else passed++;
        step();
        total++;
        if (rd_valid !== 1'b1 || rd_data !== 32'h1234)
            $display("FAIL lat_c3: got rd_valid=%b data=%h, expected 1 00001234", rd_valid, rd_data);
        else passed++;
        step();
        total++;
        if (rd_valid !== 1'b0) $display("FAIL lat_c4: got rd_valid=%b, expected 0", rd_valid); else passed++;
    endtask

    task automatic test_discard();
        int seen = 0;
        issued.delete();
        send(4'd9, 32'd1, 32'd1, "discard_send");
        for (int i = 0; i < 4; i++) begin
            if (rd_valid || mdu_ctl !== 4'hF) seen++;
            step();
        end
        total++;
        if (seen != 0 || issued.size() != 0 || req_ready !== 1'b1)
            $display("FAIL discard: got %0d active cycles, %0d issues, ready=%b, expected 0 0 1",
                     seen, issued.size(), req_ready);
        else passed++;
    endtask

    task automatic test_clr_wait();
        issued.delete();
        send(4'd7, 32'd100, 32'd7, "clr_divu");
        send(4'd2, 32'd9, 32'd0, "clr_mthi");
        send(4'd3, 32'd8, 32'd0, "clr_mtlo");
        total++;
        if (req_ready !== 1'b0) $display("FAIL clr_full: got ready=%b, expected 0", req_ready); else passed++;
        clr = 1'b1;
        #1;
        total++;
        if (mdu_ctl !== 4'hF) $display("FAIL clr_ctl_during: got %h, expected f", mdu_ctl); else passed++;
        step();
        clr = 1'b0;
        #1;
        total++;
        if (mdu_ctl !== 4'hF || req_ready !== 1'b1 || rd_valid !== 1'b0 || rd_data !== 32'd0)
            $display("FAIL clr_after: got ctl=%h ready=%b rd_valid=%b data=%h, expected f 1 0 0",
                     mdu_ctl, req_ready, rd_valid, rd_data);
        else passed++;
        step(); step(); step();
        total++;
        if (issued.size() != 1 || issued[0] !== 4'd7)
            $display("FAIL clr_flush: got %0d issues, expected only ctl 7", issued.size());
        else passed++;
    endtask

    initial begin
        test_reset();
        test_mult_mflo();
        test_divu();
        test_back_to_back();
        test_irq();
        test_mfhi_latency();
        test_discard();
        test_clr_wait();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
